fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Holds the program counter and issues single-outstanding read requests to the instruction memory/cache port.
- Presents fetched 32-bit instruction words plus their PC to decode through a registered output stage with a one-entry skid buffer.
- Supports decode stalls and branch/jump redirects from execute, including discard of in-flight responses.

Parameters:
- RESET_VECTOR, 32'h00000000: PC after reset.
- NOP_WORD, 32'h00000013: value driven on o_opcode whenever o_valid=0 (ADDI x0,x0,0).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous active-high reset.
- o_imem_addr  out  32  fetch address; bits[1:0] always 0.
- o_imem_rd  out  1  read request; address is held stable while it is high.
- i_imem_data  in  32  instruction word; valid only when i_imem_valid=1.
- i_imem_valid  in  1  response strobe; may assert in any cycle with o_imem_rd=1, including the first.
- i_stall  in  1  decode cannot accept the output this cycle.
- i_branch  in  1  redirect request; single-cycle pulse.
- i_branch_addr  in  32  redirect target; bits[1:0] are ignored (forced to 0).
- o_opcode  out  32  instruction word to decoder.
- o_pc  out  32  PC of o_opcode.
- o_valid  out  1  o_opcode/o_pc hold a live instruction.

Behaviour:
- Reset, held while i_rst=1:
  - state=BOOT, fetch_pc=RESET_VECTOR.
  - o_imem_rd=0, o_imem_addr=RESET_VECTOR.
  - o_valid=0, o_opcode=NOP_WORD, o_pc=RESET_VECTOR.
  - Skid buffer empty.
  - Reset mid-request abandons the request; any response arriving after reset deasserts is ignored in BOOT.
- Consume rule: an output word is taken in any cycle with o_valid=1 and i_stall=0. "Output free" means o_valid=0 or i_stall=0.
- States:
  - BOOT: o_imem_rd=0 -> WAIT next cycle.
  - WAIT: o_imem_rd=1, o_imem_addr=fetch_pc. When i_imem_valid=1 and i_branch=0:
    - If output free: load output (o_opcode=i_imem_data, o_pc=fetch_pc, o_valid=1); stay WAIT.
    - If output not free: load skid buffer; -> HOLD.
    - In both cases fetch_pc+=4, modulo 2^32; 32'hFFFFFFFC wraps to 0.
  - WAIT with no response: if the output is consumed, o_valid=0 next cycle.
  - HOLD: o_imem_rd=0. On consume, skid -> output (o_valid stays 1) and skid clears -> WAIT.
  - DROP: o_imem_rd=1 with the old address. On i_imem_valid the data is discarded and o_valid stays 0 -> WAIT using the redirected fetch_pc.
- Throughput: one instruction per cycle with a zero-latency memory and no stalls. Latency is 1 cycle from i_imem_valid to o_valid.
- Redirect (i_branch=1) has priority over stall, response and consume:
  - o_valid=0 and skid cleared next cycle.
  - fetch_pc = {i_branch_addr[31:2],2'b00}.
  - From WAIT with i_imem_valid=0 -> DROP. The outstanding request must complete.
  - From WAIT with i_imem_valid=1 -> WAIT. The response is discarded and the new address is requested next cycle.
  - From HOLD or BOOT -> WAIT.
  - From DROP -> stay DROP; only the latest target is kept.
- Invariants:
  - o_imem_addr changes only in a cycle after a response, after reset, or in BOOT/HOLD.
  - At most one request is outstanding.
  - o_opcode=NOP_WORD whenever o_valid=0.

Test Plan:
- Reset then zero-latency memory returning addr^32'hA5A50000, i_stall=0 -> o_pc 0,4,8,C on consecutive cycles, o_valid=1 from cycle 2.
- 3-cycle memory latency -> o_imem_addr holds 0x0 for 3 cycles; o_valid pulses once per response; o_pc 0 then 4.
- i_stall high for 4 cycles while a response arrives -> the word goes to skid and o_imem_rd=0 in HOLD; after release the output shows the skid word; no word is lost or duplicated (sequence 0,4,8 intact).
- i_branch with i_branch_addr=0x103 while a request to 0x8 is outstanding -> DROP; the 0x8 response is discarded; next request is 0x100; o_pc=0x100 is the first valid after the branch.
- i_branch concurrent with i_stall=1 and a full skid -> next cycle o_valid=0 and o_opcode=0x00000013; next request is to the target.
- i_branch_addr=0xFFFFFFFC -> o_pc sequence 0xFFFFFFFC, 0x00000000; reset asserted mid-WAIT -> outputs return to reset values next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues single-outstanding reads, presents words to decode.
// Latency: 1 cycle from i_imem_valid to o_valid; one instruction per cycle with zero-latency memory.
// Backpressure: i_stall parks a returning word in a one-entry skid buffer and pauses requests until it drains.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD     = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_rd,
    input  logic [31:0] i_imem_data,
    input  logic        i_imem_valid,
    input  logic        i_stall,
    input  logic        i_branch,
    input  logic [31:0] i_branch_addr,
    output logic [31:0] o_opcode,
    output logic [31:0] o_pc,
    output logic        o_valid
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_imem_addr;
    logic [31:0] r_out_op;
    logic [31:0] r_out_pc;
    logic        r_out_vld;
    logic [31:0] r_skid_op;
    logic [31:0] r_skid_pc;
    logic        r_skid_vld;

    state_t      w_state_nxt;
    logic [31:0] w_fetch_pc_nxt;
    logic [31:0] w_imem_addr_nxt;
    logic [31:0] w_out_op_nxt;
    logic [31:0] w_out_pc_nxt;
    logic        w_out_vld_nxt;
    logic [31:0] w_skid_op_nxt;
    logic [31:0] w_skid_pc_nxt;
    logic        w_skid_vld_nxt;
    logic        w_consume;
    logic        w_out_free;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    assign w_consume  = r_out_vld && !i_stall;
    assign w_out_free = !r_out_vld || !i_stall;
    assign w_target   = {i_branch_addr[31:2], 2'b00};
    // Natural 32-bit wrap: 0xFFFFFFFC + 4 rolls over to 0.
    assign w_pc_inc   = r_fetch_pc + 32'd4;

    // A request is live in WAIT and DROP; in DROP it targets the pre-redirect address.
    assign o_imem_rd   = (r_state == S_WAIT) || (r_state == S_DROP);
    assign o_imem_addr = r_imem_addr;
    assign o_opcode    = r_out_op;
    assign o_pc        = r_out_pc;
    assign o_valid     = r_out_vld;

    // Next-state, PC, output-stage and skid-buffer decisions; a redirect overrides everything else.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_out_op_nxt   = r_out_op;
        w_out_pc_nxt   = r_out_pc;
        w_out_vld_nxt  = r_out_vld;
        w_skid_op_nxt  = r_skid_op;
        w_skid_pc_nxt  = r_skid_pc;
        w_skid_vld_nxt = r_skid_vld;

        // A consumed word empties the output unless something refills it below.
        if (w_consume) begin
            w_out_vld_nxt = 1'b0;
            w_out_op_nxt  = NOP_WORD;
        end

        if (i_branch) begin
            w_out_vld_nxt  = 1'b0;
            w_out_op_nxt   = NOP_WORD;
            w_skid_vld_nxt = 1'b0;
            w_fetch_pc_nxt = w_target;
            case (r_state)
                // Without a response the old request is still in flight and must be drained.
                S_WAIT:  w_state_nxt = i_imem_valid ? S_WAIT : S_DROP;
                S_DROP:  w_state_nxt = S_DROP;
                default: w_state_nxt = S_WAIT;
            endcase
        end else begin
            case (r_state)
                S_BOOT: begin
                    w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (i_imem_valid) begin
                        w_fetch_pc_nxt = w_pc_inc;
                        if (w_out_free) begin
                            w_out_op_nxt  = i_imem_data;
                            w_out_pc_nxt  = r_fetch_pc;
                            w_out_vld_nxt = 1'b1;
                        end else begin
                            w_skid_op_nxt  = i_imem_data;
                            w_skid_pc_nxt  = r_fetch_pc;
                            w_skid_vld_nxt = 1'b1;
                            w_state_nxt    = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_consume) begin
                        w_out_op_nxt   = r_skid_op;
                        w_out_pc_nxt   = r_skid_pc;
                        w_out_vld_nxt  = 1'b1;
                        w_skid_vld_nxt = 1'b0;
                        w_state_nxt    = S_WAIT;
                    end
                end
                S_DROP: begin
                    if (i_imem_valid) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                default: begin
                    w_state_nxt = S_BOOT;
                end
            endcase
        end

        // While draining a stale request the address must stay on the old PC.
        w_imem_addr_nxt = (w_state_nxt == S_DROP) ? r_imem_addr : w_fetch_pc_nxt;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_BOOT;
            r_fetch_pc  <= RESET_VECTOR;
            r_imem_addr <= RESET_VECTOR;
            r_out_op    <= NOP_WORD;
            r_out_pc    <= RESET_VECTOR;
            r_out_vld   <= 1'b0;
            r_skid_op   <= NOP_WORD;
            r_skid_pc   <= RESET_VECTOR;
            r_skid_vld  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_imem_addr <= w_imem_addr_nxt;
            r_out_op    <= w_out_op_nxt;
            r_out_pc    <= w_out_pc_nxt;
            r_out_vld   <= w_out_vld_nxt;
            r_skid_op   <= w_skid_op_nxt;
            r_skid_pc   <= w_skid_pc_nxt;
            r_skid_vld  <= w_skid_vld_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of per-cycle inputs and expected outputs, plus short hand sequences.
// Each row drives inputs after a rising edge, checks outputs mid-cycle, then advances one clock.
// Memory responses come from the row itself; returned data is the expected address XOR a fixed key.
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] N   = 32'h0000_0013;

    logic        i_clk;
    logic        i_rst;
    logic [31:0] o_imem_addr;
    logic        o_imem_rd;
    logic [31:0] i_imem_data;
    logic        i_imem_valid;
    logic        i_stall;
    logic        i_branch;
    logic [31:0] i_branch_addr;
    logic [31:0] o_opcode;
    logic [31:0] o_pc;
    logic        o_valid;

    fetch_unit dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .o_imem_addr  (o_imem_addr),
        .o_imem_rd    (o_imem_rd),
        .i_imem_data  (i_imem_data),
        .i_imem_valid (i_imem_valid),
        .i_stall      (i_stall),
        .i_branch     (i_branch),
        .i_branch_addr(i_branch_addr),
        .o_opcode     (o_opcode),
        .o_pc         (o_pc),
        .o_valid      (o_valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] baddr;
        logic        mv;
        logic        exp_rd;
        logic [31:0] exp_addr;
        logic        exp_vld;
        logic [31:0] exp_pc;
        logic [31:0] exp_op;
    } vec_t;

    vec_t vq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input logic rst, input logic stall, input logic br, input logic [31:0] baddr,
                       input logic mv, input logic rd, input logic [31:0] addr, input logic vld,
                       input logic [31:0] pc, input logic [31:0] op);
        vec_t v;
        v.rst = rst; v.stall = stall; v.br = br; v.baddr = baddr; v.mv = mv;
        v.exp_rd = rd; v.exp_addr = addr; v.exp_vld = vld; v.exp_pc = pc; v.exp_op = op;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %h, expected %h", name, tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then clock.
    task automatic step(input string tag, input vec_t v);
        i_rst         = v.rst;
        i_stall       = v.stall;
        i_branch      = v.br;
        i_branch_addr = v.baddr;
        i_imem_valid  = v.mv;
        i_imem_data   = v.mv ? (v.exp_addr ^ KEY) : 32'h0;
        #1;
        chk("imem_rd",   tag, {31'b0, o_imem_rd}, {31'b0, v.exp_rd});
        chk("imem_addr", tag, o_imem_addr, v.exp_addr);
        chk("valid",     tag, {31'b0, o_valid}, {31'b0, v.exp_vld});
        chk("pc",        tag, o_pc, v.exp_pc);
        chk("opcode",    tag, o_opcode, v.exp_op);
        @(posedge i_clk);
        #1;
    endtask

    task automatic hstep(input string tag, input logic stall, input logic br, input logic [31:0] baddr,
                         input logic mv, input logic rd, input logic [31:0] addr, input logic vld,
                         input logic [31:0] pc, input logic [31:0] op);
        vec_t v;
        v.rst = 1'b0; v.stall = stall; v.br = br; v.baddr = baddr; v.mv = mv;
        v.exp_rd = rd; v.exp_addr = addr; v.exp_vld = vld; v.exp_pc = pc; v.exp_op = op;
        step(tag, v);
    endtask

    initial begin
        //   rst stall br baddr          mv | rd addr           vld pc             op
        // reset values, then zero-latency memory, no stall
        add(1, 0, 0, 32'h0,          0,   0, 32'h0,          0, 32'h0,          N);
        add(0, 0, 0, 32'h0,          0,   0, 32'h0,          0, 32'h0,          N);
        add(0, 0, 0, 32'h0,          1,   1, 32'h0,          0, 32'h0,          N);
        add(0, 0, 0, 32'h0,          1,   1, 32'h4,          1, 32'h0,          32'hA5A50000);
        add(0, 0, 0, 32'h0,          1,   1, 32'h8,          1, 32'h4,          32'hA5A50004);
        add(0, 0, 0, 32'h0,          1,   1, 32'hC,          1, 32'h8,          32'hA5A50008);
        add(0, 0, 0, 32'h0,          0,   1, 32'h10,         1, 32'hC,          32'hA5A5000C);
        add(0, 0, 0, 32'h0,          0,   1, 32'h10,         0, 32'hC,          N);
        // reset, then 3-cycle memory latency
        add(1, 0, 0, 32'h0,          0,   1, 32'h10,         0, 32'hC,          N);
        add(0, 0, 0, 32'h0,          0,   0, 32'h0,          0, 32'h0,          N);
        add(0, 0, 0, 32'h0,          0,   1, 32'h0,          0, 32'h0,          N);
        add(0, 0, 0, 32'h0,          0,   1, 32'h0,          0, 32'h0,          N);
        add(0, 0, 0, 32'h0,          1,   1, 32'h0,          0, 32'h0,          N);
        add(0, 0, 0, 32'h0,          0,   1, 32'h4,          1, 32'h0,          32'hA5A50000);
        add(0, 0, 0, 32'h0,          0,   1, 32'h4,          0, 32'h0,          N);
        add(0, 0, 0, 32'h0,          0,   1, 32'h4,          0, 32'h0,          N);
        add(0, 0, 0, 32'h0,          1,   1, 32'h4,          0, 32'h0,          N);
        add(0, 0, 0, 32'h0,          0,   1, 32'h8,          1, 32'h4,          32'hA5A50004);
        // 4-cycle stall while a response arrives: skid, HOLD, drain in order 8,C,10
        add(0, 0, 0, 32'h0,          1,   1, 32'h8,          0, 32'h4,          N);
        add(0, 1, 0, 32'h0,          1,   1, 32'hC,          1, 32'h8,          32'hA5A50008);
        add(0, 1, 0, 32'h0,          0,   0, 32'h10,         1, 32'h8,          32'hA5A50008);
        add(0, 1, 0, 32'h0,          0,   0, 32'h10,         1, 32'h8,          32'hA5A50008);
        add(0, 1, 0, 32'h0,          0,   0, 32'h10,         1, 32'h8,          32'hA5A50008);
        add(0, 0, 0, 32'h0,          0,   0, 32'h10,         1, 32'h8,          32'hA5A50008);
        add(0, 0, 0, 32'h0,          1,   1, 32'h10,         1, 32'hC,          32'hA5A5000C);
        add(0, 0, 0, 32'h0,          0,   1, 32'h14,         1, 32'h10,         32'hA5A50010);
        // branch to 0x103 with a request outstanding: DROP, discard, then fetch 0x100
        add(0, 0, 1, 32'h103,        0,   1, 32'h14,         0, 32'h10,         N);
        add(0, 0, 0, 32'h0,          0,   1, 32'h14,         0, 32'h10,         N);
        add(0, 0, 0, 32'h0,          1,   1, 32'h14,         0, 32'h10,         N);
        add(0, 0, 0, 32'h0,          1,   1, 32'h100,        0, 32'h10,         N);
        add(0, 0, 0, 32'h0,          0,   1, 32'h104,        1, 32'h100,        32'hA5A50100);
        // branch to 0xFFFFFFFC with stall and full skid; then wrap to 0
        add(0, 0, 0, 32'h0,          1,   1, 32'h104,        0, 32'h100,        N);
        add(0, 1, 0, 32'h0,          1,   1, 32'h108,        1, 32'h104,        32'hA5A50104);
        add(0, 1, 1, 32'hFFFFFFFC,   0,   0, 32'h10C,        1, 32'h104,        32'hA5A50104);
        add(0, 0, 0, 32'h0,          1,   1, 32'hFFFFFFFC,   0, 32'h104,        N);
        add(0, 0, 0, 32'h0,          1,   1, 32'h0,          1, 32'hFFFFFFFC,   32'h5A5AFFFC);
        // reset mid-WAIT; a late response in BOOT is ignored
        add(1, 0, 0, 32'h0,          0,   1, 32'h4,          1, 32'h0,          32'hA5A50000);
        add(0, 0, 0, 32'h0,          1,   0, 32'h0,          0, 32'h0,          N);
        add(0, 0, 0, 32'h0,          0,   1, 32'h0,          0, 32'h0,          N);
        // branch coinciding with a response: response discarded, target fetched next
        add(0, 0, 1, 32'h40,         1,   1, 32'h0,          0, 32'h0,          N);
        add(0, 0, 0, 32'h0,          1,   1, 32'h40,         0, 32'h0,          N);
        add(0, 0, 0, 32'h0,          0,   1, 32'h44,         1, 32'h40,         32'hA5A50040);

        i_rst = 1'b1; i_stall = 1'b0; i_branch = 1'b0; i_branch_addr = 32'h0;
        i_imem_valid = 1'b0; i_imem_data = 32'h0;
        repeat (2) @(posedge i_clk);
        #1;

        foreach (vq[i]) begin
            step($sformatf("row%0d", i), vq[i]);
        end

        // Back-to-back redirects while draining: only the latest target survives.
        hstep("drop_a", 0, 1, 32'h200, 0, 1, 32'h44,  0, 32'h40,  N);
        hstep("drop_b", 0, 1, 32'h301, 0, 1, 32'h44,  0, 32'h40,  N);
        hstep("drop_c", 0, 0, 32'h0,   1, 1, 32'h44,  0, 32'h40,  N);
        hstep("drop_d", 0, 0, 32'h0,   1, 1, 32'h300, 0, 32'h40,  N);
        hstep("drop_e", 0, 0, 32'h0,   0, 1, 32'h304, 1, 32'h300, 32'hA5A50300);

        // Stall released then reasserted around back-to-back responses: no word lost or repeated.
        hstep("stl_a",  0, 0, 32'h0,   1, 1, 32'h304, 0, 32'h300, N);
        hstep("stl_b",  1, 0, 32'h0,   1, 1, 32'h308, 1, 32'h304, 32'hA5A50304);
        hstep("stl_c",  0, 0, 32'h0,   0, 0, 32'h30C, 1, 32'h304, 32'hA5A50304);
        hstep("stl_d",  0, 0, 32'h0,   1, 1, 32'h30C, 1, 32'h308, 32'hA5A50308);
        hstep("stl_e",  0, 0, 32'h0,   0, 1, 32'h310, 1, 32'h30C, 32'hA5A5030C);
        hstep("stl_f",  0, 0, 32'h0,   0, 1, 32'h310, 0, 32'h30C, N);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
